// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stop codes, exception codes
// and FSM states.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam logic [5:0] STOP_NONE  = 6'b000000;
   localparam logic [5:0] STOP_IF    = 6'b000011;
   localparam logic [5:0] STOP_ID    = 6'b000111;
   localparam logic [5:0] STOP_EX    = 6'b001111;
   localparam logic [5:0] STOP_MEM   = 6'b011111;
   localparam logic [5:0] STOP_DRAIN = 6'b111111;

   localparam logic [31:0] DEF_ERET_TYPE  = 32'h0000_000e;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0020;

   // Later stages win; a MEM stall leaves WB running so mem_wb takes a bubble.
   function automatic logic [5:0] stall_code(input logic req_if, input logic req_id,
                                             input logic req_ex, input logic req_mem);
      logic [5:0] code;
      code = STOP_NONE;
      if (req_mem)     code = STOP_MEM;
      else if (req_ex) code = STOP_EX;
      else if (req_id) code = STOP_ID;
      else if (req_if) code = STOP_IF;
      return code;
   endfunction

endpackage

// File: rtl/pipe_ctrl_stall_mon.sv
// Debug stall monitor: saturating total stall count plus a consecutive-stall
// watchdog with a sticky timeout flag.
module ctrl_stall_mon
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W     = 32,
   parameter logic [15:0] MAX_STALL = 16'd1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_stop0,
   input  logic             i_flush,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic             o_stall_timeout
);

   logic [CNT_W-1:0] r_cycles;
   logic [15:0]      r_cons;
   logic             r_timeout;
   logic             w_stalled;
   logic [15:0]      w_cons_nxt;

   assign w_stalled  = (i_stop0 == Stop) && (i_flush == NoStop);
   assign w_cons_nxt = (r_cons == MAX_STALL) ? r_cons : r_cons + 16'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cycles  <= '0;
         r_cons    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (i_stop0 && !(&r_cycles))
            r_cycles <= r_cycles + CNT_W'(1);
         if (w_stalled) begin
            r_cons <= w_cons_nxt;
            if (w_cons_nxt == MAX_STALL)
               r_timeout <= 1'b1;
         end else begin
            r_cons <= '0;
         end
      end
   end

   assign o_stall_cycles  = r_cycles;
   assign o_stall_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merge, exception/ERET flush sequencing
// with data-bus drain, and stall debug counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
   parameter logic [31:0] ERET_TYPE  = DEF_ERET_TYPE,
   parameter logic [15:0] MAX_STALL  = 16'd1024,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stallreq_if,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic [31:0]      excepttype_i,
   input  logic [31:0]      cp0_epc_i,
   input  logic             dbus_busy_i,
   output logic [5:0]       stop,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             stall_timeout
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_exc;
   logic [31:0] r_epc;
   logic        w_exc;

   assign w_exc = (excepttype_i != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (w_exc && dbus_busy_i) w_state_nxt = DRAIN;
         DRAIN:   if (!dbus_busy_i)         w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // Exception captured on DRAIN entry; EPC may move while the bus drains.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_exc <= '0;
         r_epc <= '0;
      end else if (r_state == RUN && w_exc && dbus_busy_i) begin
         r_exc <= excepttype_i;
         r_epc <= cp0_epc_i;
      end
   end

   always_comb begin
      stop   = STOP_NONE;
      flush  = 1'b0;
      new_pc = '0;
      if (rst_n) begin
         case (r_state)
            RUN: begin
               if (w_exc) begin
                  if (dbus_busy_i) begin
                     stop = STOP_DRAIN;
                  end else begin
                     flush  = 1'b1;
                     new_pc = (excepttype_i == ERET_TYPE) ? cp0_epc_i : EXC_VECTOR;
                  end
               end else begin
                  stop = stall_code(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
               end
            end
            DRAIN: begin
               if (dbus_busy_i) begin
                  stop = STOP_DRAIN;
               end else begin
                  flush  = 1'b1;
                  new_pc = (r_exc == ERET_TYPE) ? r_epc : EXC_VECTOR;
               end
            end
            default: ;
         endcase
      end
   end

   ctrl_stall_mon #(
      .CNT_W     (CNT_W),
      .MAX_STALL (MAX_STALL)
   ) u_stall_mon (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_stop0         (stop[0]),
      .i_flush         (flush),
      .o_stall_cycles  (stall_cycles),
      .o_stall_timeout (stall_timeout)
   );

endmodule
